// File: rtl/apb_pkg.sv
// Shared types, constants and sizing helpers for the APB register-file completer.
package apb_pkg;

    typedef enum logic {
        APB_IDLE,
        APB_ACCESS
    } apb_state_e;

    localparam int DATA_W_DEF = 32;
    localparam int STRB_W     = DATA_W_DEF / 8;
    localparam int ADDR_LSB   = $clog2(STRB_W);

    // Width of a register index; a single register still needs one bit.
    function automatic int idx_width(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

    function automatic int cnt_width(input int wait_cycles);
        return (wait_cycles > 0) ? $clog2(wait_cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// Register storage with a byte-strobed write port, one read port and a
// flattened view of every register for downstream logic.
module apb_reg_bank
    import apb_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                NUM_REGS  = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    localparam int               NB        = DATA_W / 8,
    localparam int               IDX_W     = idx_width(NUM_REGS)
) (
    input  logic                         pclk,
    input  logic                         preset_n,
    input  logic                         we_i,
    input  logic [IDX_W-1:0]             idx_i,
    input  logic [DATA_W-1:0]            wdata_i,
    input  logic [NB-1:0]                wstrb_i,
    output logic [DATA_W-1:0]            rdata_o,
    output logic [NUM_REGS*DATA_W-1:0]   regs_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];

    // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        regs_d = regs_q;
        if (we_i) begin
            for (int b = 0; b < NB; b++) begin
                if (wstrb_i[b]) begin
                    regs_d[idx_i][b*8 +: 8] = wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // NOTE: non-blocking assignments in always_ff so all registers update together from pre-edge values.
    // NOTE: this bank is reset on purpose; downstream logic consumes regs_o directly, so a RAM macro without reset is not an option here.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata_o = regs_q[idx_i];

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign regs_o[i*DATA_W +: DATA_W] = regs_q[i];
    end

endmodule

// File: rtl/apb_regfile_slave.sv
// APB4 completer: setup/access FSM with programmable wait states, address and
// read-only decode into an error response, and a gated read mux over the bank.
module apb_regfile_slave
    import apb_pkg::*;
#(
    parameter int                  DATA_W      = DATA_W_DEF,
    parameter int                  ADDR_W      = 12,
    parameter int                  NUM_REGS    = 8,
    parameter int                  WAIT_CYCLES = 1,
    parameter logic [NUM_REGS-1:0] RO_MASK     = '0,
    parameter logic [DATA_W-1:0]   RESET_VAL   = '0
) (
    input  logic                        pclk,
    input  logic                        preset_n,
    input  logic                        psel_i,
    input  logic                        penable_i,
    input  logic [ADDR_W-1:0]           paddr_i,
    input  logic                        pwrite_i,
    input  logic [DATA_W-1:0]           pwdata_i,
    input  logic [DATA_W/8-1:0]         pstrb_i,
    output logic [DATA_W-1:0]           prdata_o,
    output logic                        pready_o,
    output logic                        pslverr_o,
    output logic [NUM_REGS*DATA_W-1:0]  regs_o
);

    localparam int              NB         = DATA_W / 8;
    localparam int              LSB        = $clog2(NB);
    localparam int              IDX_W      = idx_width(NUM_REGS);
    localparam int              CNT_W      = cnt_width(WAIT_CYCLES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(NB - 1);
    localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

    apb_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                err_q;
    logic                write_q;
    logic [IDX_W-1:0]    idx_q;

    logic [ADDR_W-1:0]   word_idx;
    logic                misaligned;
    logic                out_of_range;
    logic                ro_hit;
    logic                err_d;
    logic                complete;
    logic                bank_we;
    logic [DATA_W-1:0]   bank_rdata;

    assign word_idx     = paddr_i >> LSB;
    assign misaligned   = |(paddr_i & ALIGN_MASK);
    assign out_of_range = (word_idx >= NUM_REGS_A);

    always_comb begin
        ro_hit = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (word_idx == ADDR_W'(i)) begin
                ro_hit = RO_MASK[i];
            end
        end
    end

    assign err_d = misaligned || out_of_range || (pwrite_i && ro_hit);

    // Response decodes only from registered state, never from bus inputs.
    assign pready_o  = (state_q == APB_ACCESS) && (cnt_q == '0);
    assign pslverr_o = pready_o && err_q;
    assign prdata_o  = (pready_o && !write_q && !err_q) ? bank_rdata : '0;

    assign complete = psel_i && penable_i && pready_o;
    assign bank_we  = complete && write_q && !err_q;

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q <= APB_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            write_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                APB_IDLE: begin
                    if (psel_i && !penable_i) begin
                        state_q <= APB_ACCESS;
                        cnt_q   <= CNT_W'(WAIT_CYCLES);
                        err_q   <= err_d;
                        write_q <= pwrite_i;
                        idx_q   <= word_idx[IDX_W-1:0];
                    end
                end
                APB_ACCESS: begin
                    // Dropping psel/penable before pready aborts silently.
                    if (!(psel_i && penable_i) || pready_o) begin
                        state_q <= APB_IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= APB_IDLE;
            endcase
        end
    end

    apb_reg_bank #(
        .DATA_W    (DATA_W),
        .NUM_REGS  (NUM_REGS),
        .RESET_VAL (RESET_VAL)
    ) u_bank (
        .pclk     (pclk),
        .preset_n (preset_n),
        .we_i     (bank_we),
        .idx_i    (idx_q),
        .wdata_i  (pwdata_i),
        .wstrb_i  (pstrb_i),
        .rdata_o  (bank_rdata),
        .regs_o   (regs_o)
    );

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Bench for apb_regfile_slave: three instances (0, 1 and 3 wait states) on a
// shared bus, a vector table, directed corner cases and randomized traffic.
module tb_apb_regfile_slave;
    import apb_pkg::*;

    localparam int NR = 8;

    logic pclk = 1'b0;
    logic preset_n = 1'b0;
    always #5 pclk = ~pclk;

    logic [2:0]        psel = '0;
    logic              penable = 1'b0;
    logic              pwrite = 1'b0;
    logic [11:0]       paddr = '0;
    logic [31:0]       pwdata = '0;
    logic [STRB_W-1:0] pstrb = '0;

    logic [31:0]       prdata  [3];
    logic              pready  [3];
    logic              pslverr [3];
    logic [NR*32-1:0]  regs    [3];

    int          wc [3] = '{0, 1, 3};
    logic [7:0]  ro [3] = '{8'h01, 8'h80, 8'h0C};
    logic [31:0] rv [3] = '{32'h0, 32'h0, 32'h0000_A5A5};

    apb_regfile_slave #(.DATA_W(32), .ADDR_W(12), .NUM_REGS(NR), .WAIT_CYCLES(0),
                        .RO_MASK(8'h01), .RESET_VAL(32'h0)) u_dut0 (
        .pclk(pclk), .preset_n(preset_n), .psel_i(psel[0]), .penable_i(penable),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .prdata_o(prdata[0]), .pready_o(pready[0]), .pslverr_o(pslverr[0]), .regs_o(regs[0]));

    apb_regfile_slave #(.DATA_W(32), .ADDR_W(12), .NUM_REGS(NR), .WAIT_CYCLES(1),
                        .RO_MASK(8'h80), .RESET_VAL(32'h0)) u_dut1 (
        .pclk(pclk), .preset_n(preset_n), .psel_i(psel[1]), .penable_i(penable),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .prdata_o(prdata[1]), .pready_o(pready[1]), .pslverr_o(pslverr[1]), .regs_o(regs[1]));

    apb_regfile_slave #(.DATA_W(32), .ADDR_W(12), .NUM_REGS(NR), .WAIT_CYCLES(3),
                        .RO_MASK(8'h0C), .RESET_VAL(32'h0000_A5A5)) u_dut3 (
        .pclk(pclk), .preset_n(preset_n), .psel_i(psel[2]), .penable_i(penable),
        .paddr_i(paddr), .pwrite_i(pwrite), .pwdata_i(pwdata), .pstrb_i(pstrb),
        .prdata_o(prdata[2]), .pready_o(pready[2]), .pslverr_o(pslverr[2]), .regs_o(regs[2]));

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one word array per instance, updated from the bus rules.
    logic [31:0] mem [3][NR];

    task automatic model_reset();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < NR; i++)
                mem[d][i] = rv[d];
    endtask

    task automatic model_xfer(input int d, input bit wr, input logic [11:0] addr,
                              input logic [31:0] data, input logic [3:0] strb,
                              output logic [31:0] rd, output bit er);
        int word;
        word = int'(addr) / 4;
        er = (int'(addr) % 4 != 0) || (word >= NR) || (wr && word < NR && ro[d][word]);
        rd = '0;
        if (!er && !wr) rd = mem[d][word];
        if (!er && wr)
            for (int b = 0; b < 4; b++)
                if (strb[b]) mem[d][word][8*b +: 8] = data[8*b +: 8];
    endtask

    // Called one step after a rising edge; returns one step after the completion edge.
    task automatic xfer(input int d, input bit wr, input logic [11:0] addr,
                        input logic [31:0] data, input logic [3:0] strb,
                        output logic [31:0] rd, output logic er, output int cyc);
        psel = '0;
        psel[d] = 1'b1;
        penable = 1'b0;
        paddr = addr;
        pwrite = wr;
        pwdata = data;
        pstrb = strb;
        check("pready_in_setup", 64'(pready[d]), 64'(0));
        @(posedge pclk); #1;
        penable = 1'b1;
        cyc = 1;
        while (!pready[d] && cyc < 20) begin
            @(posedge pclk); #1;
            cyc++;
        end
        check("pready_seen", 64'(pready[d]), 64'(1));
        rd = prdata[d];
        er = pslverr[d];
        @(posedge pclk); #1;
        psel = '0;
        penable = 1'b0;
    endtask

    task automatic xfer_chk(input string name, input int d, input bit wr,
                            input logic [11:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [31:0] exp_rd,
                            input bit exp_er);
        logic [31:0] rd;
        logic        er;
        int          cyc;
        xfer(d, wr, addr, data, strb, rd, er, cyc);
        check({name, "_prdata"}, 64'(rd), 64'(exp_rd));
        check({name, "_pslverr"}, 64'(er), 64'(exp_er));
        check({name, "_cycles"}, 64'(cyc), 64'(wc[d] + 1));
    endtask

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    vec_t tbl [13];

    initial begin
        logic [31:0] m_rd;
        bit          m_er;
        bit          wr;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          d;
        int          r;

        tbl[0]  = '{1'b0, 12'h000, 32'h0,         4'h0, 32'h0,         1'b0};
        tbl[1]  = '{1'b1, 12'h004, 32'hDEADBEEF,  4'hF, 32'h0,         1'b0};
        tbl[2]  = '{1'b0, 12'h004, 32'h0,         4'h0, 32'hDEADBEEF,  1'b0};
        tbl[3]  = '{1'b1, 12'h008, 32'hAABBCCDD,  4'hF, 32'h0,         1'b0};
        tbl[4]  = '{1'b1, 12'h008, 32'h11223344,  4'h5, 32'h0,         1'b0};
        tbl[5]  = '{1'b0, 12'h008, 32'h0,         4'hF, 32'hAA22CC44,  1'b0};
        tbl[6]  = '{1'b0, 12'h020, 32'h0,         4'h0, 32'h0,         1'b1};
        tbl[7]  = '{1'b1, 12'h020, 32'hFFFFFFFF,  4'hF, 32'h0,         1'b1};
        tbl[8]  = '{1'b0, 12'h006, 32'h0,         4'h0, 32'h0,         1'b1};
        tbl[9]  = '{1'b1, 12'h006, 32'h55555555,  4'hF, 32'h0,         1'b1};
        tbl[10] = '{1'b0, 12'h004, 32'h0,         4'h0, 32'hDEADBEEF,  1'b0};
        tbl[11] = '{1'b1, 12'h01C, 32'h12345678,  4'hF, 32'h0,         1'b1};
        tbl[12] = '{1'b0, 12'h01C, 32'h0,         4'h0, 32'h0,         1'b0};

        model_reset();
        #12;
        for (int k = 0; k < 3; k++) begin
            check("rst_pready", 64'(pready[k]), 64'(0));
            check("rst_pslverr", 64'(pslverr[k]), 64'(0));
            check("rst_prdata", 64'(prdata[k]), 64'(0));
        end
        check("rst_regs3_w7", 64'(regs[2][7*32 +: 32]), 64'(32'h0000_A5A5));
        preset_n = 1'b1;
        @(posedge pclk); #1;

        // Vector table on the one-wait-state instance.
        for (int i = 0; i < 13; i++) begin
            model_xfer(1, tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].strb, m_rd, m_er);
            xfer_chk($sformatf("vec%0d", i), 1, tbl[i].wr, tbl[i].addr, tbl[i].data,
                     tbl[i].strb, tbl[i].exp_rd, tbl[i].exp_err);
        end
        check("regs_o_w1", 64'(regs[1][63:32]), 64'(32'hDEADBEEF));
        check("regs_o_w2", 64'(regs[1][95:64]), 64'(32'hAA22CC44));
        check("regs_o_w7", 64'(regs[1][255:224]), 64'(32'h0));

        // Zero-wait back-to-back write then read, and the three-wait instance.
        model_xfer(0, 1'b1, 12'h010, 32'h0BADF00D, 4'hF, m_rd, m_er);
        xfer_chk("b2b_wr", 0, 1'b1, 12'h010, 32'h0BADF00D, 4'hF, 32'h0, 1'b0);
        model_xfer(0, 1'b0, 12'h010, 32'h0, 4'h0, m_rd, m_er);
        xfer_chk("b2b_rd", 0, 1'b0, 12'h010, 32'h0, 4'h0, 32'h0BADF00D, 1'b0);
        model_xfer(0, 1'b1, 12'h000, 32'hFFFFFFFF, 4'hF, m_rd, m_er);
        xfer_chk("ro_wr0", 0, 1'b1, 12'h000, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
        model_xfer(2, 1'b0, 12'h000, 32'h0, 4'h0, m_rd, m_er);
        xfer_chk("w3_rd", 2, 1'b0, 12'h000, 32'h0, 4'h0, 32'h0000_A5A5, 1'b0);
        model_xfer(2, 1'b1, 12'h008, 32'h12345678, 4'hF, m_rd, m_er);
        xfer_chk("w3_ro", 2, 1'b1, 12'h008, 32'h12345678, 4'hF, 32'h0, 1'b1);
        check("w3_ro_kept", 64'(regs[2][95:64]), 64'(32'h0000_A5A5));

        // Abort: drop psel in the second access cycle of a three-wait write.
        psel = 3'b100; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h010; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = '0; penable = 1'b0;
        @(posedge pclk); #1;
        check("abort_pready", 64'(pready[2]), 64'(0));
        check("abort_nowrite", 64'(regs[2][4*32 +: 32]), 64'(32'h0000_A5A5));
        model_xfer(2, 1'b0, 12'h010, 32'h0, 4'h0, m_rd, m_er);
        xfer_chk("after_abort", 2, 1'b0, 12'h010, 32'h0, 4'h0, 32'h0000_A5A5, 1'b0);

        // Reset pulse while a write on the one-wait instance is ready.
        psel = 3'b010; penable = 1'b0; pwrite = 1'b1;
        paddr = 12'h00C; pwdata = 32'h13579BDF; pstrb = 4'hF;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        check("pre_rst_pready", 64'(pready[1]), 64'(1));
        #1 preset_n = 1'b0;
        #1;
        check("mid_rst_pready", 64'(pready[1]), 64'(0));
        check("mid_rst_pslverr", 64'(pslverr[1]), 64'(0));
        check("mid_rst_regs1_w1", 64'(regs[1][63:32]), 64'(32'h0));
        check("mid_rst_regs1_w3", 64'(regs[1][127:96]), 64'(32'h0));
        check("mid_rst_regs0_w4", 64'(regs[0][159:128]), 64'(32'h0));
        check("mid_rst_regs3_w4", 64'(regs[2][159:128]), 64'(32'h0000_A5A5));
        psel = '0; penable = 1'b0;
        #2 preset_n = 1'b1;
        model_reset();
        @(posedge pclk); #1;
        xfer_chk("post_rst_rd", 1, 1'b0, 12'h004, 32'h0, 4'h0, 32'h0, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 60; i++) begin
            d = int'($urandom_range(0, 2));
            wr = 1'($urandom_range(0, 1));
            r = int'($urandom_range(0, 11));
            if (r < 9) addr = 12'(r * 4);
            else addr = 12'($urandom_range(0, 9) * 4 + $urandom_range(1, 3));
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            model_xfer(d, wr, addr, data, strb, m_rd, m_er);
            xfer_chk($sformatf("rnd%0d", i), d, wr, addr, data, strb, m_rd, m_er);
        end

        for (int k = 0; k < 3; k++)
            for (int i = 0; i < NR; i++)
                check($sformatf("final_d%0d_r%0d", k, i), 64'(regs[k][i*32 +: 32]), 64'(mem[k][i]));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_regfile_slave.md
# apb_regfile_slave

Parametrised APB4 completer holding a bank of memory-mapped registers, with programmable wait states, byte strobes and error response. It replaces the fixed one-wait-state, random-data slave model used on the bench. It sits behind the APB requester as the first real register target and exports all register contents to downstream logic.

## Interface
- DATA_W, 32: PWDATA/PRDATA width; must be a multiple of 8 and at most 64.
- ADDR_W, 12: PADDR width.
- NUM_REGS, 8: number of registers, at least 2.
- WAIT_CYCLES, 1: wait states inserted before PREADY; 0 gives zero-wait transfers.
- RO_MASK, 0: bit i set means register i is read-only.
- RESET_VAL, 0: reset value of every register; DATA_W wide.
- pclk  in  1  APB clock; everything samples on the rising edge.
- preset_n  in  1  reset, asynchronous, active-low.
- psel_i  in  1  completer select.
- penable_i  in  1  access-phase indicator.
- paddr_i  in  ADDR_W  byte address.
- pwrite_i  in  1  1 = write, 0 = read.
- pwdata_i  in  DATA_W  write data.
- pstrb_i  in  DATA_W/8  byte write strobes.
- prdata_o  out  DATA_W  read data; 0 except when completing a good read.
- pready_o  out  1  transfer completion.
- pslverr_o  out  1  error response; only meaningful while pready_o is high.
- regs_o  out  NUM_REGS*DATA_W  flattened register contents, register 0 in the LSBs.

## Operation
- The FSM has two states, IDLE and ACCESS. Reset state is IDLE, and a wait counter resets to 0.
- IDLE to ACCESS: the rising edge sees psel_i=1 and penable_i=0 (setup phase). On that edge:
  - load the counter with WAIT_CYCLES;
  - latch the error flag `err`.
- err is set if any of these holds:
  - the low log2(DATA_W/8) address bits are non-zero (misaligned);
  - the word index paddr_i >> log2(DATA_W/8) is greater than or equal to NUM_REGS;
  - pwrite_i=1 and the target register's RO_MASK bit is set.
- In ACCESS, the counter decrements by 1 each cycle while non-zero.
- pready_o = (state==ACCESS) && (counter==0). It is decoded only from registers, so it never depends combinationally on inputs.
- pslverr_o = pready_o && err.
- prdata_o = register[index] when pready_o && !pwrite_i && !err; otherwise 0.
- Completion edge is psel_i && penable_i && pready_o:
  - A good write updates byte k of the register only where pstrb_i[k]=1; other bytes keep their value.
  - An erroring write leaves every register unchanged.
  - The FSM returns to IDLE, so a back-to-back setup phase on the next cycle is accepted.
- Abort: in ACCESS, if psel_i or penable_i drops before completion, the FSM returns to IDLE with no write and no response.
- pstrb_i is ignored on reads.
- regs_o always reflects current register state. A write is visible on the cycle after the completion edge.

## Timing
- Reset values: pready_o=0, pslverr_o=0, prdata_o=0, every register = RESET_VAL. These hold immediately on preset_n low, independent of pclk.
- Transfer length is setup + (WAIT_CYCLES+1) access cycles.
  - WAIT_CYCLES=0: pready_o is high in the first access cycle (2-cycle transfer).
  - WAIT_CYCLES=1: pready_o is high in the second access cycle.
- Reset asserted mid-transfer: the FSM goes to IDLE, the counter clears, the in-flight write is lost, and registers return to RESET_VAL.
- Write data and strobes are sampled on the completion edge only. Address and direction are taken from the setup edge.
- prdata_o is stable for the whole cycle in which pready_o is high.
- pready_o is low in IDLE, including a setup cycle that arrives while idle.

## Structure
- Shared package apb_pkg holds:
  - the state typedef (APB_IDLE, APB_ACCESS);
  - localparams STRB_W = DATA_W/8 and ADDR_LSB = $clog2(STRB_W);
  - an index-width helper function.
- One sub-module, apb_reg_bank: register storage, strobe-masked write port, async reset to RESET_VAL, flattened regs_o.
- The top level contains the FSM, wait counter, decode/error logic and read mux.

## Test plan
- Reset to read: release reset; read address 0x0 with WAIT_CYCLES=1 -> pready_o in the 3rd cycle from setup, prdata_o=0, pslverr_o=0.
- Full write, then read: write 0xDEADBEEF to 0x4 with pstrb=4'hF, then read 0x4 -> 0xDEADBEEF; regs_o[63:32]=0xDEADBEEF.
- Partial strobes: write 0x11223344 to 0x8 with pstrb=4'b0101 over an old value of 0xAABBCCDD -> reads back 0xAA22CC44.
- Errors, each giving pslverr_o=1 and no state change:
  - address 0x20 with NUM_REGS=8 (out of range);
  - address 0x6 (misaligned);
  - write to a RO_MASK register.
  - Erroring reads return prdata_o=0.
- Wait-state sweep: WAIT_CYCLES=0 and WAIT_CYCLES=3 -> pready_o after exactly 1 and 4 access cycles. A back-to-back write then read completes without an IDLE gap.
- Abort and reset:
  - deassert psel_i mid-ACCESS -> no write; the next transfer proceeds normally.
  - pulse preset_n low during a write's access phase -> outputs go to 0 immediately and registers return to RESET_VAL.
